// File: rtl/onstate_rr_sched.sv
// rtl/onstate_rr_sched.sv - round-robin owner scheduler for a shared on-state engine
module onstate_rr_sched #(
    parameter int NREQ   = 4,
    parameter int TO_CYC = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            clr_err,
    input  logic            eng_f,
    output logic            eng_do,
    output logic [NREQ-1:0] grant,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int              OW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0]      TO_LAST   = 8'(TO_CYC - 1);
    localparam logic [OW-1:0]   LAST_INIT = OW'(NREQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_OWN, S_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   last_owner_q, last_owner_d;
    logic            abort_q, abort_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            eng_do_q, eng_do_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [OW-1:0]   winner;
    logic            win_found;
    logic            timeout_evt;
    logic            done_evt;
    logic            owner_req;

    assign owner_req = req[owner_q];
    assign grant     = grant_q;
    assign eng_do    = eng_do_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

    // Round-robin search starting one past the previous owner
    always_comb begin
        int            idx;
        logic [OW-1:0] cand;
        idx       = 0;
        cand      = '0;
        winner    = last_owner_q;
        win_found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx  = (int'(last_owner_q) + i) % NREQ;
            cand = OW'(idx);
            if (!win_found && req[cand]) begin
                winner    = cand;
                win_found = 1'b1;
            end
        end
    end

    // State register; reset drops the engine command and grant immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            owner_q      <= '0;
            last_owner_q <= LAST_INIT;
            abort_q      <= 1'b0;
            grant_q      <= '0;
            eng_do_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            abort_q      <= abort_d;
            grant_q      <= grant_d;
            eng_do_q     <= eng_do_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Next state; eng_f is tested before the timeout so it wins a tie
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        abort_d      = abort_q;
        timeout_evt  = 1'b0;
        done_evt     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_ARM;
                    owner_d = winner;
                    cnt_d   = '0;
                end
            end
            S_ARM: begin
                if (eng_f) begin
                    state_d = S_OWN;
                    cnt_d   = '0;
                end else if (!owner_req) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                    abort_d = 1'b1;
                end else if (cnt_q == TO_LAST) begin
                    state_d     = S_DRAIN;
                    cnt_d       = '0;
                    abort_d     = 1'b1;
                    timeout_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_OWN: begin
                if (!owner_req) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                    abort_d = 1'b0;
                end
            end
            S_DRAIN: begin
                if (!eng_f) begin
                    state_d      = S_IDLE;
                    cnt_d        = '0;
                    last_owner_d = owner_q;
                    done_evt     = !abort_q;
                end else if (cnt_q == TO_LAST) begin
                    state_d      = S_IDLE;
                    cnt_d        = '0;
                    last_owner_d = owner_q;
                    timeout_evt  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs derived from the state being entered
    always_comb begin
        grant_d  = '0;
        eng_do_d = 1'b0;
        if (state_d == S_ARM || state_d == S_OWN) begin
            grant_d[owner_d] = 1'b1;
            eng_do_d         = 1'b1;
        end
        busy_d = (state_d != S_IDLE);
        done_d = done_evt;
        err_d  = (err_q & ~clr_err) | timeout_evt;
    end

endmodule

// File: tb/tb_onstate_rr_sched.sv
// tb/tb_onstate_rr_sched.sv - self-checking bench for onstate_rr_sched
module tb_onstate_rr_sched;

    localparam int NREQ   = 4;
    localparam int TO_CYC = 16;
    localparam int P_IDLE = 0, P_ARM = 1, P_OWN = 2, P_DRAIN = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic            clr_err;
    logic            eng_f;
    logic            eng_do;
    logic [NREQ-1:0] grant;
    logic            busy;
    logic            done;
    logic            err;

    int checks = 0;
    int errors = 0;

    // reference model: phase, cycles spent in phase, owner bookkeeping
    int m_phase, m_age, m_owner, m_last;
    bit m_err, m_done, m_clean;

    // engine model: 0 = follow eng_do after eng_dly cycles, 1 = stuck 0, 2 = stuck 1
    int eng_mode, eng_dly, eng_cnt;

    always #5 clk = ~clk;

    onstate_rr_sched #(.NREQ(NREQ), .TO_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst), .req(req), .clr_err(clr_err), .eng_f(eng_f),
        .eng_do(eng_do), .grant(grant), .busy(busy), .done(done), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_phase = P_IDLE; m_age = 0; m_owner = 0; m_last = NREQ - 1;
        m_err = 0; m_done = 0; m_clean = 0;
    endfunction

    function automatic void model_step();
        bit to;
        bit found;
        to = 0; found = 0; m_done = 0;
        case (m_phase)
            P_IDLE: begin
                for (int i = 1; i <= NREQ; i++) begin
                    if (!found && req[(m_last + i) % NREQ]) begin
                        m_owner = (m_last + i) % NREQ;
                        found = 1;
                    end
                end
                if (found) begin m_phase = P_ARM; m_age = 0; end
            end
            P_ARM: begin
                if (eng_f) begin m_phase = P_OWN; m_age = 0; end
                else if (!req[m_owner]) begin m_phase = P_DRAIN; m_age = 0; m_clean = 0; end
                else if (m_age == TO_CYC - 1) begin m_phase = P_DRAIN; m_age = 0; m_clean = 0; to = 1; end
                else m_age++;
            end
            P_OWN: begin
                if (!req[m_owner]) begin m_phase = P_DRAIN; m_age = 0; m_clean = 1; end
            end
            default: begin
                if (!eng_f) begin m_phase = P_IDLE; m_last = m_owner; m_done = m_clean; end
                else if (m_age == TO_CYC - 1) begin m_phase = P_IDLE; m_last = m_owner; to = 1; end
                else m_age++;
            end
        endcase
        m_err = (m_err && !clr_err) || to;
    endfunction

    function automatic logic [NREQ-1:0] m_grant();
        logic [NREQ-1:0] g;
        g = '0;
        if (m_phase == P_ARM || m_phase == P_OWN) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic engine_step();
        case (eng_mode)
            1: eng_f = 1'b0;
            2: eng_f = 1'b1;
            default: begin
                if (eng_do !== eng_f) begin
                    eng_cnt++;
                    if (eng_cnt >= eng_dly) begin eng_f = eng_do; eng_cnt = 0; end
                end else eng_cnt = 0;
            end
        endcase
    endtask

    task automatic tick();
        logic [NREQ-1:0] g;
        @(posedge clk);
        model_step();
        @(negedge clk);
        g = m_grant();
        chk("grant", 32'(grant), 32'(g));
        chk("eng_do", 32'(eng_do), 32'(g != '0));
        chk("busy", 32'(busy), 32'(m_phase != P_IDLE));
        chk("done", 32'(done), 32'(m_done));
        chk("err", 32'(err), 32'(m_err));
        engine_step();
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; clr_err = 1'b0; eng_f = 1'b0;
        eng_mode = 0; eng_dly = 2; eng_cnt = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        req = '0; eng_mode = 0; eng_dly = 1;
        for (int i = 0; i < 60; i++) begin
            if (m_phase == P_IDLE && busy === 1'b0) break;
            tick();
        end
        chk("wait_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int own_cnt;
        int ndone;
        logic [NREQ-1:0] prev_g;
        logic [NREQ-1:0] seq[$];
        logic [NREQ-1:0] exp_seq[5];

        // reset state
        do_reset();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_eng_do", 32'(eng_do), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // single request, engine answers 2 cycles after eng_do
        req = 4'b0001;
        tick();
        chk("single_arm_grant", 32'(grant), 32'h1);
        tick(); tick();
        chk("single_own_grant", 32'(grant), 32'h1);
        tick(); tick();
        req = 4'b0000;
        tick();
        chk("single_drain_grant", 32'(grant), 32'h0);
        chk("single_drain_do", 32'(eng_do), 32'h0);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin tick(); if (done === 1'b1) ndone++; end
        chk("single_done_pulses", 32'(ndone), 32'd1);
        chk("single_err", 32'(err), 32'd0);

        // contention: all request, each drops after 3 OWN cycles and re-raises
        do_reset();
        req = 4'b1111; own_cnt = 0; prev_g = '0;
        for (int i = 0; i < 200 && seq.size() < 5; i++) begin
            tick();
            if (grant !== '0 && prev_g === '0) seq.push_back(grant);
            prev_g = grant;
            if (m_phase == P_OWN) begin
                own_cnt++;
                if (own_cnt == 3) begin req[m_owner] = 1'b0; own_cnt = 0; end
            end
            if (req != 4'b1111 && grant === '0) req = 4'b1111;
        end
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        chk("rr_count", 32'(seq.size()), 32'd5);
        for (int i = 0; i < 5 && i < seq.size(); i++) chk("rr_order", 32'(seq[i]), 32'(exp_seq[i]));

        // ARM timeout with eng_f held low
        do_reset();
        eng_mode = 1; req = 4'b0001;
        tick();
        n = 0;
        for (int i = 0; i < 40; i++) begin tick(); n++; if (grant === '0) break; end
        chk("arm_to_cycles", 32'(n), 32'd16);
        chk("arm_to_err", 32'(err), 32'd1);
        chk("arm_to_busy", 32'(busy), 32'd1);
        tick();
        chk("arm_to_nodone", 32'(done), 32'd0);
        chk("arm_to_sticky", 32'(err), 32'd1);
        req = '0; clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("arm_to_clr", 32'(err), 32'd0);

        // abandon in ARM, next winner follows the abandoning owner
        req = 4'b0100;
        tick();
        chk("abandon_arm", 32'(grant), 32'h4);
        req = 4'b1001;
        tick();
        chk("abandon_drain", 32'(grant), 32'h0);
        tick();
        chk("abandon_nodone", 32'(done), 32'd0);
        tick();
        chk("abandon_next", 32'(grant), 32'h8);
        chk("abandon_err", 32'(err), 32'd0);
        wait_idle();

        // eng_f and ARM timeout in the same cycle: eng_f wins
        eng_mode = 1; req = 4'b0001;
        tick();
        repeat (15) tick();
        eng_mode = 2; eng_f = 1'b1;
        tick();
        chk("tie_own", 32'(grant), 32'h1);
        chk("tie_err", 32'(err), 32'd0);

        // DRAIN timeout with eng_f stuck high: err, no done
        req = '0;
        tick();
        n = 0;
        for (int i = 0; i < 40; i++) begin tick(); n++; if (busy === 1'b0) break; end
        chk("drain_to_cycles", 32'(n), 32'd16);
        chk("drain_to_err", 32'(err), 32'd1);
        chk("drain_to_nodone", 32'(done), 32'd0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_err", 32'(err), 32'd0);
        wait_idle();

        // asynchronous reset during OWN
        eng_mode = 0; eng_dly = 1; req = 4'b0010;
        for (int i = 0; i < 10; i++) begin tick(); if (m_phase == P_OWN) break; end
        chk("arst_own", 32'(grant), 32'h2);
        #2 rst = 1'b1;
        #1;
        chk("arst_grant", 32'(grant), 32'h0);
        chk("arst_do", 32'(eng_do), 32'h0);
        chk("arst_done", 32'(done), 32'h0);
        model_reset(); eng_f = 1'b0; eng_cnt = 0; req = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("arst_first", 32'(grant), 32'h1);

        // randomized traffic against the model
        for (int c = 0; c < 1200; c++) begin
            if (c % 100 == 0) begin
                n = int'($urandom_range(0, 5));
                if (n < 4) begin eng_mode = 0; eng_dly = n + 1; end
                else eng_mode = n - 3;
            end
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            clr_err = ($urandom_range(0, 11) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/onstate_rr_sched.md
ONSTATE_RR_SCHED -- requirements
Module: onstate_rr_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TO_CYC, default 16, timeout in cycles for engine handshake phases (2..255).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  NREQ  per-requester request; held high for the whole ownership period.
REQ-006 SHALL have port clr_err  input  1  synchronous clear of err.
REQ-007 SHALL have port eng_f  input  1  registered on-state flag returned by the shared engine.
REQ-008 SHALL have port eng_do  output  1  engine command (do) driven to the shared engine.
REQ-009 SHALL have port grant  output  NREQ  one-hot owner indication, registered.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse on normal completion of an ownership.
REQ-012 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-013 SHALL implement FSM states IDLE, ARM, OWN, DRAIN; all outputs registered.
REQ-014 SHALL in IDLE, when any req bit is high, select the winner by round-robin starting at (last_owner+1) mod NREQ, enter ARM next cycle with grant = winner one-hot and eng_do = 1.
REQ-015 SHALL in ARM, on eng_f = 1, enter OWN; grant and eng_do stay high.
REQ-016 SHALL in ARM, if req[owner] drops before eng_f = 1, enter DRAIN (abandon) with eng_do = 0 and grant = 0; no err.
REQ-017 SHALL in OWN, when req[owner] = 0, enter DRAIN with eng_do = 0 and grant = 0 the next cycle.
REQ-018 SHALL in DRAIN, on eng_f = 0, enter IDLE and pulse done for exactly one cycle (the first IDLE cycle).
REQ-019 SHALL keep an 8-bit timeout counter cleared on every state entry, incrementing each cycle in ARM and DRAIN only.
REQ-020 SHALL, when the counter equals TO_CYC-1 in ARM and eng_f = 0, enter DRAIN and set err.
REQ-021 SHALL, when the counter equals TO_CYC-1 in DRAIN and eng_f = 1, enter IDLE, set err, and not pulse done.
REQ-022 SHALL give eng_f priority over timeout when both occur in the same cycle.
REQ-023 SHALL update last_owner to the owner on every exit from DRAIN (normal, abandon or timeout).
REQ-024 SHALL ignore req changes of non-owners while not in IDLE; grant never changes owner without passing through IDLE.
REQ-025 SHALL guarantee grant is zero or one-hot in every cycle.
REQ-026 SHALL clear err on clr_err = 1; a timeout in the same cycle as clr_err leaves err = 1.
REQ-027 SHALL need at least one IDLE cycle between consecutive ownerships (minimum grant gap 1 cycle).

Reset
REQ-028 SHALL on rst = 1 asynchronously force state IDLE, grant = 0, eng_do = 0, busy = 0, done = 0, err = 0, counter = 0, last_owner = NREQ-1 (so requester 0 wins first).
REQ-029 SHALL, on reset asserted mid-ownership, drop eng_do and grant immediately without done pulse.

Verification
REQ-030 SHALL cover single request: req = 0001, engine returns eng_f 2 cycles after eng_do -> grant = 0001, OWN, req drop -> eng_do = 0, eng_f low -> done pulse 1 cycle, err = 0.
REQ-031 SHALL cover contention: req = 1111 held, each requester drops after 3 OWN cycles and re-raises -> grant order 0001, 0010, 0100, 1000, 0001.
REQ-032 SHALL cover ARM timeout: TO_CYC = 16, eng_f held 0 -> DRAIN exactly 16 cycles after ARM entry, err = 1, grant = 0, no done.
REQ-033 SHALL cover abandon: req[2] drops while in ARM -> DRAIN, no err, next winner is requester 3 when req = 1001.
REQ-034 SHALL cover simultaneous eng_f = 1 and timeout in ARM -> OWN, err stays 0; then clr_err with err = 1 -> err = 0 next cycle.
REQ-035 SHALL cover rst pulse during OWN -> eng_do = 0, grant = 0 without waiting for a clk edge; after release, requester 0 wins first.
